// File: rtl/pattern_lock_fsm.sv
// Link-alignment state machine: hunts for a pattern in the decoder's match flags,
// verifies it over LOCK_CNT hits, and tolerates up to UNLOCK_CNT-1 consecutive misses once locked.
module pattern_lock_fsm #(
    parameter int NUM_PATTERNS = 4,
    parameter int LOCK_CNT     = 4,
    parameter int UNLOCK_CNT   = 3,
    parameter int ERR_W        = 16
) (
    input  logic                            clk_i,
    input  logic                            rstn_clk_ni,
    input  logic [NUM_PATTERNS-1:0]         match_i,
    input  logic                            valid_i,
    input  logic                            resync_i,
    input  logic                            err_clr_i,
    output logic                            locked_o,
    output logic [$clog2(NUM_PATTERNS)-1:0] pattern_idx_o,
    output logic                            lock_acq_o,
    output logic                            lock_lost_o,
    output logic [ERR_W-1:0]                err_cnt_o
);

    localparam int IDX_W   = $clog2(NUM_PATTERNS);
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, FLYWHEEL} state_t;

    state_t           state;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             hit;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_PATTERNS-1:0] m);
        lowest_idx = '0;
        for (int k = NUM_PATTERNS - 1; k >= 0; k--)
            if (m[k]) lowest_idx = IDX_W'(k);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    // pattern_idx_o doubles as the candidate register
    assign hit = match_i[pattern_idx_o];

    always_ff @(posedge clk_i or negedge rstn_clk_ni) begin
        if (!rstn_clk_ni) begin
            state         <= HUNT;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            pattern_idx_o <= '0;
            locked_o      <= 1'b0;
            lock_acq_o    <= 1'b0;
            lock_lost_o   <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            lock_acq_o  <= 1'b0;
            lock_lost_o <= 1'b0;
            if (resync_i) begin
                state       <= HUNT;
                hit_cnt     <= '0;
                miss_cnt    <= '0;
                locked_o    <= 1'b0;
                lock_lost_o <= locked_o;
            end else if (valid_i) begin
                case (state)
                    HUNT: begin
                        if (|match_i) begin
                            pattern_idx_o <= lowest_idx(match_i);
                            hit_cnt       <= CNT_W'(1);
                            if (LOCK_CNT == 1) begin
                                state      <= LOCKED;
                                locked_o   <= 1'b1;
                                lock_acq_o <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            hit_cnt <= hit_cnt + 1'b1;
                            if (hit_cnt == LOCK_LAST) begin
                                state      <= LOCKED;
                                locked_o   <= 1'b1;
                                lock_acq_o <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            hit_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!hit) begin
                            err_cnt_o <= sat_inc(err_cnt_o);
                            if (UNLOCK_CNT == 1) begin
                                state       <= HUNT;
                                hit_cnt     <= '0;
                                locked_o    <= 1'b0;
                                lock_lost_o <= 1'b1;
                            end else begin
                                state    <= FLYWHEEL;
                                miss_cnt <= CNT_W'(1);
                            end
                        end
                    end
                    FLYWHEEL: begin
                        if (hit) begin
                            state    <= LOCKED;
                            miss_cnt <= '0;
                        end else begin
                            err_cnt_o <= sat_inc(err_cnt_o);
                            if (miss_cnt == UNLOCK_LAST) begin
                                state       <= HUNT;
                                hit_cnt     <= '0;
                                miss_cnt    <= '0;
                                locked_o    <= 1'b0;
                                lock_lost_o <= 1'b1;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            // Clear takes priority over any increment made above
            if (err_clr_i) err_cnt_o <= '0;
        end
    end

endmodule
